// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive types, line idle level and baud counter sizing.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic IDLE_LEVEL = 1'b1;
  function automatic int baud_cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction
endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: show-ahead receive FIFO; a push into a full FIFO is dropped unless a pop frees the slot.
module rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic push_ok, pop_ok;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop = push & ~push_ok;
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + {{(AW-1){1'b0}}, push_ok};
      rp <= rp + {{(AW-1){1'b0}}, pop_ok};
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampling UART receiver feeding a small FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to add a parity bit (polarity from PARITY_ODD) and the parity_err output.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             rx,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
`ifdef UART_RX_PARITY_EN
  , output logic           parity_err
`endif
);
  localparam int CW = baud_cnt_width(CLKS_PER_BIT);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  rx_state_t state, state_n;
  logic rx_m, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] sh;
  logic half, tick, push, drop, empty, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic perr_set;
`endif
  assign half = cnt == CW'(CLKS_PER_BIT/2 - 1);
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign busy = state != IDLE;
  assign valid = ~empty;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) {rx_m, rx_s, rx_d} <= {3{IDLE_LEVEL}};
    else {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
  always_comb begin
    state_n = state;
    push = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      IDLE:  state_n = (rx_d == IDLE_LEVEL && rx_s != IDLE_LEVEL) ? START : IDLE;
      START: state_n = !half ? START : (rx_s == IDLE_LEVEL ? IDLE : DATA);
`ifdef UART_RX_PARITY_EN
      DATA:  state_n = (tick && idx == IW'(WIDTH-1)) ? PARITY : DATA;
      PARITY: begin
        state_n = tick ? STOP : PARITY;
        perr_set = tick & (rx_s != (^sh ^ PARITY_ODD[0]));
      end
`else
      DATA:  state_n = (tick && idx == IW'(WIDTH-1)) ? STOP : DATA;
`endif
      STOP: begin
        state_n = tick ? IDLE : STOP;
        push = tick & rx_s;
        ferr_set = tick & ~rx_s;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state != state_n || tick) ? '0 : cnt + 1'b1;
      idx <= state != DATA ? '0 : idx + IW'(tick);
      if (state == DATA && tick) sh <= {rx_s, sh[WIDTH-1:1]};
      frame_err <= ferr_set | (frame_err & ~clr_err);
      overrun <= drop | (overrun & ~clr_err);
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) parity_err <= 1'b0;
    else parity_err <= perr_set | (parity_err & ~clr_err);
`endif
  rx_sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .arst_n(arst_n), .push(push), .pop(rd_en), .din(sh),
    .dout(rd_data), .full(full), .empty(empty), .drop(drop)
  );
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed and random frames checked against a queue-based reference model.
module tb_uart_rx_buffered;
  localparam int CPB = 16, DEPTH = 4;
  logic clk = 0, arst_n = 0, rx = 1, rd_en = 0, clr_err = 0;
  logic [7:0] rd_data;
  logic valid, full, busy, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  bit m_pe;
`endif
  int tests = 0, fails = 0, cyc = 0, start_cyc = 0, rise_cyc = -1;
  bit m_fe, m_ov, busy_seen, valid_q;
  byte unsigned q[$];

  uart_rx_buffered #(.WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut (
    .clk(clk), .arst_n(arst_n), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .valid(valid),
    .full(full), .busy(busy), .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (busy) busy_seen = 1;
    if (valid && !valid_q && rise_cyc < 0) rise_cyc = cyc;
    valid_q = valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".rd_data"}, 32'(rd_data), q.size() != 0 ? 32'(q[0]) : 32'd0);
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
    check({tag, ".busy"}, 32'(busy), 32'd0);
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_err"}, 32'(parity_err), 32'(m_pe));
`endif
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input int gap, input bit pflip = 0);
    @(negedge clk);
    rx = 0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b ^ pflip;
    repeat (CPB) @(negedge clk);
    if (pflip) m_pe = 1;
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1;
    repeat (gap) @(negedge clk);
    if (!stop) m_fe = 1;
    else if (q.size() == DEPTH) m_ov = 1;
    else q.push_back(b);
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    check_all({tag, ".pre"});
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    if (q.size() != 0) void'(q.pop_front());
    check_all({tag, ".post"});
  endtask

  task automatic clear(input string tag);
    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    m_fe = 0;
    m_ov = 0;
`ifdef UART_RX_PARITY_EN
    m_pe = 0;
`endif
    check_all(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    check_all("reset");
    send(8'hA5, 1, 6);
    check("t1.latency", 32'(rise_cyc - start_cyc >= 150 && rise_cyc - start_cyc <= 165), 1);
    check_all("t1");
    pop("t1");
    for (int i = 1; i <= 5; i++) send(8'(i), 1, 4);
    check_all("t2");
    for (int i = 0; i < 5; i++) pop("t2");
    clear("t2.clr");
    send(8'h3C, 0, 6);
    check_all("t3");
    clear("t3.clr");
    busy_seen = 0;
    @(negedge clk);
    rx = 0;
    repeat (4) @(negedge clk);
    rx = 1;
    repeat (40) @(negedge clk);
    check("t4.busy_pulse", 32'(busy_seen), 1);
    check_all("t4");
    send(8'h11, 1, 4);
    send(8'h22, 0, 4);
    @(negedge clk);
    rx = 0;
    repeat (CPB) @(negedge clk);
    rx = 1;
    repeat (4 * CPB) @(negedge clk);
    arst_n = 0;
    rx = 1;
    #1;
    q.delete();
    m_fe = 0;
    m_ov = 0;
`ifdef UART_RX_PARITY_EN
    m_pe = 0;
`endif
    check_all("t5.reset");
    @(negedge clk);
    arst_n = 1;
    send(8'h5A, 1, 6);
    check_all("t5");
    pop("t5");
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1, 6, 1);
    check_all("t6");
    pop("t6");
    clear("t6.clr");
`endif
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(4, 12));
      check_all("rnd");
      repeat ($urandom_range(0, 2)) pop("rnd");
      if ($urandom_range(0, 4) == 0) clear("rnd.clr");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
